// File: rtl/lock_alarm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg (package)
// Purpose  : Shared types and helpers for the lock alarm controller: the
//            controller state encoding, the failure-counter width and the
//            functions that turn the frequency/duration parameters into
//            clock-cycle counts and counter widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

    // Width of the consecutive-failure counter (MAX_FAIL is limited to 1..7).
    localparam int FAIL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALARM   = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_CHIRP   = 2'd3
    } state_t;

    // Cycles per buzzer half-period.
    function automatic int half_cycles(input int clk_hz, input int buzz_hz);
        return clk_hz / (2 * buzz_hz);
    endfunction

    // Cycles the buzzer sounds after a single failed attempt.
    function automatic int alarm_cycles(input int clk_hz, input int alarm_ms);
        return (clk_hz / 1000) * alarm_ms;
    endfunction

    // Cycles per second of lockout.
    function automatic int sec_cycles(input int clk_hz);
        return clk_hz;
    endfunction

    // Cycles of the confirmation chirp (100 ms).
    function automatic int chirp_cycles(input int clk_hz);
        return clk_hz / 10;
    endfunction

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lock_alarm_ctrl_if
// Purpose  : Groups the comparator-facing levels and the alarm outputs of the
//            lock alarm controller.
// Signals  : open_i   - comparator open level (async to clk)
//            alarm_i  - comparator alarm level (async to clk)
//            buzzer   - buzzer square-wave drive, active-high
//            lockout  - active-high, gates the upstream enable key
//            led_lock - lockout LED, active-low
//            fail_cnt - consecutive-failure count
// Modports : master - comparator/board side (drives open_i, alarm_i)
//            slave  - controller side (drives the outputs)
// Revision : 1.0 - initial release
// ============================================================================
interface lock_alarm_ctrl_if;

    logic                         open_i;
    logic                         alarm_i;
    logic                         buzzer;
    logic                         lockout;
    logic                         led_lock;
    logic [lock_pkg::FAIL_W-1:0]  fail_cnt;

    modport master (
        output open_i,
        output alarm_i,
        input  buzzer,
        input  lockout,
        input  led_lock,
        input  fail_cnt
    );

    modport slave (
        input  open_i,
        input  alarm_i,
        output buzzer,
        output lockout,
        output led_lock,
        output fail_cnt
    );

endinterface
`default_nettype wire

// File: rtl/lock_alarm_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : lock_sync_edge
// Purpose  : Two-flop synchronizer followed by a rising-edge detector. An
//            input edge yields a one-cycle pulse visible after the second
//            clock edge, so the consumer acts on the third edge.
// Ports    : clk     - system clock
//            rst_n   - asynchronous active-low reset
//            d_i     - asynchronous level input
//            pulse_o - one-cycle pulse on a synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module lock_sync_edge (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  d_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // prev_q clears with the synchronizer so a level held high across reset
    // release is still seen as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/lock_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_alarm_ctrl
// Purpose  : Downstream stage of the 4-bit coded lock comparator. Counts
//            consecutive failed attempts, sounds a timed buzzer after each
//            failure and, after MAX_FAIL failures, holds a timed lockout that
//            gates the upstream enable key.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            bus   - lock_alarm_ctrl_if.slave (open_i, alarm_i in;
//                    buzzer, lockout, led_lock, fail_cnt out)
// Options  : BEEP_ON_OPEN_EN - when defined, an accepted open produces a
//            100 ms double-frequency chirp (CHIRP state).
// Revision : 1.0 - initial release
// ============================================================================
module lock_alarm_ctrl
    import lock_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int BUZZ_HZ   = 2000,
    parameter int ALARM_MS  = 1000,
    parameter int MAX_FAIL  = 3,
    parameter int LOCKOUT_S = 10
) (
    input  wire               clk,
    input  wire               rst_n,
    lock_alarm_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // Cycle counts and counter widths
    // ------------------------------------------------------------------
    localparam int c_half_cyc  = half_cycles(CLK_HZ, BUZZ_HZ);
    localparam int c_alarm_cyc = alarm_cycles(CLK_HZ, ALARM_MS);
    localparam int c_sec_cyc   = sec_cycles(CLK_HZ);
`ifdef BEEP_ON_OPEN_EN
    localparam int c_chirp_half = (c_half_cyc / 2 > 0) ? c_half_cyc / 2 : 1;
    localparam int c_chirp_cyc  = chirp_cycles(CLK_HZ);
    localparam int c_tmr_max    = (c_chirp_cyc > c_alarm_cyc) ? c_chirp_cyc : c_alarm_cyc;
`else
    localparam int c_tmr_max    = c_alarm_cyc;
`endif

    localparam int c_tone_w = cnt_width(c_half_cyc);
    localparam int c_tmr_w  = cnt_width(c_tmr_max);
    localparam int c_sec_w  = cnt_width(c_sec_cyc);
    localparam int c_snum_w = cnt_width(LOCKOUT_S);

    localparam logic [c_tone_w-1:0] c_half_last  = c_tone_w'(c_half_cyc - 1);
    localparam logic [c_tmr_w-1:0]  c_alarm_last = c_tmr_w'(c_alarm_cyc - 1);
    localparam logic [c_sec_w-1:0]  c_sec_last   = c_sec_w'(c_sec_cyc - 1);
    localparam logic [c_sec_w-1:0]  c_sec_mid    = c_sec_w'(c_sec_cyc / 2);
    localparam logic [c_snum_w-1:0] c_lock_last  = c_snum_w'(LOCKOUT_S - 1);
    localparam logic [FAIL_W-1:0]   c_max_fail   = FAIL_W'(MAX_FAIL);
`ifdef BEEP_ON_OPEN_EN
    localparam logic [c_tone_w-1:0] c_chirp_last     = c_tone_w'(c_chirp_half - 1);
    localparam logic [c_tmr_w-1:0]  c_chirp_tmr_last = c_tmr_w'(c_chirp_cyc - 1);
`endif

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic open_p;
    logic alarm_p;

    lock_sync_edge u_sync_open (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.open_i),
        .pulse_o (open_p)
    );

    lock_sync_edge u_sync_alarm (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.alarm_i),
        .pulse_o (alarm_p)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [FAIL_W-1:0]     fail_q,     fail_d;
    logic [c_tone_w-1:0]   tone_cnt_q, tone_cnt_d;
    logic                  tone_q,     tone_d;
    logic [c_tmr_w-1:0]    tmr_q,      tmr_d;
    logic [c_sec_w-1:0]    sec_cnt_q,  sec_cnt_d;
    logic [c_snum_w-1:0]   sec_num_q,  sec_num_d;
    logic                  buzzer_q,   buzzer_d;

    logic [FAIL_W-1:0]     fail_inc;
    logic                  fail_hit;
    logic [c_tone_w-1:0]   tone_last;
    logic                  enter_alarm;
    logic                  enter_lock;
    logic                  enter_idle;
`ifdef BEEP_ON_OPEN_EN
    logic                  enter_chirp;
`endif

    assign fail_inc = fail_q + FAIL_W'(1);
    assign fail_hit = (fail_inc >= c_max_fail);

    // The chirp runs the shared tone divider at twice the normal rate.
`ifdef BEEP_ON_OPEN_EN
    assign tone_last = (state_q == ST_CHIRP) ? c_chirp_last : c_half_last;
`else
    assign tone_last = c_half_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fail_q     <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            tmr_q      <= '0;
            sec_cnt_q  <= '0;
            sec_num_q  <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            tmr_q      <= tmr_d;
            sec_cnt_q  <= sec_cnt_d;
            sec_num_q  <= sec_num_d;
            buzzer_q   <= buzzer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fail_d      = fail_q;
        tmr_d       = tmr_q;
        sec_cnt_d   = sec_cnt_q;
        sec_num_d   = sec_num_q;
        buzzer_d    = 1'b0;
        enter_alarm = 1'b0;
        enter_lock  = 1'b0;
        enter_idle  = 1'b0;
`ifdef BEEP_ON_OPEN_EN
        enter_chirp = 1'b0;
`endif

        // Free-running tone divider; IDLE and state entries override it.
        if (tone_cnt_q == tone_last) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
        end else begin
            tone_cnt_d = tone_cnt_q + c_tone_w'(1);
            tone_d     = tone_q;
        end

        case (state_q)
            ST_IDLE: begin
                tone_cnt_d = '0;
                tone_d     = 1'b0;
                // alarm_p has priority over a coincident open_p.
                if (alarm_p) begin
                    fail_d = fail_inc;
                    if (fail_hit) enter_lock  = 1'b1;
                    else          enter_alarm = 1'b1;
                end else if (open_p) begin
                    fail_d = '0;
`ifdef BEEP_ON_OPEN_EN
                    enter_chirp = 1'b1;
`endif
                end
            end

            ST_ALARM: begin
                if (alarm_p) begin
                    // Re-alarm extends the buzz without restarting the tone.
                    fail_d = fail_inc;
                    if (fail_hit) enter_lock = 1'b1;
                    else          tmr_d      = '0;
                end else if (open_p) begin
                    fail_d = '0;
`ifdef BEEP_ON_OPEN_EN
                    enter_chirp = 1'b1;
`else
                    enter_idle  = 1'b1;
`endif
                end else if (tmr_q == c_alarm_last) begin
                    enter_idle = 1'b1;
                end else begin
                    tmr_d = tmr_q + c_tmr_w'(1);
                end
            end

            ST_LOCKOUT: begin
                // Comparator pulses are deliberately ignored here.
                if (sec_cnt_q == c_sec_last) begin
                    sec_cnt_d = '0;
                    if (sec_num_q == c_lock_last) begin
                        fail_d     = '0;
                        enter_idle = 1'b1;
                    end else begin
                        sec_num_d = sec_num_q + c_snum_w'(1);
                    end
                end else begin
                    sec_cnt_d = sec_cnt_q + c_sec_w'(1);
                end
            end

            ST_CHIRP: begin
`ifdef BEEP_ON_OPEN_EN
                if (alarm_p) begin
                    fail_d = fail_inc;
                    if (fail_hit) enter_lock  = 1'b1;
                    else          enter_alarm = 1'b1;
                end else if (tmr_q == c_chirp_tmr_last) begin
                    enter_idle = 1'b1;
                end else begin
                    tmr_d = tmr_q + c_tmr_w'(1);
                end
`else
                enter_idle = 1'b1;
`endif
            end

            default: enter_idle = 1'b1;
        endcase

        // Every state entry restarts the tone low.
        if (enter_alarm) begin
            state_d    = ST_ALARM;
            tmr_d      = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
        if (enter_lock) begin
            state_d    = ST_LOCKOUT;
            sec_cnt_d  = '0;
            sec_num_d  = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
        if (enter_idle) begin
            state_d    = ST_IDLE;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
`ifdef BEEP_ON_OPEN_EN
        if (enter_chirp) begin
            state_d    = ST_CHIRP;
            tmr_d      = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
`endif

        // Registered buzzer: lockout only sounds in the first half-second.
        case (state_d)
            ST_ALARM:   buzzer_d = tone_d;
            ST_CHIRP:   buzzer_d = tone_d;
            ST_LOCKOUT: buzzer_d = tone_d & (sec_cnt_d < c_sec_mid);
            default:    buzzer_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.buzzer   = buzzer_q;
    assign bus.lockout  = (state_q == ST_LOCKOUT);
    assign bus.led_lock = (state_q != ST_LOCKOUT);
    assign bus.fail_cnt = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_alarm_ctrl
// Purpose  : Directed self-checking bench for lock_alarm_ctrl with
//            CLK_HZ=1000, BUZZ_HZ=100 (HALF=5), ALARM_MS=20 (20 cycles),
//            MAX_FAIL=3, LOCKOUT_S=1 (1000 cycles). Honours BEEP_ON_OPEN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_alarm_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    lock_alarm_ctrl_if bus ();

    lock_alarm_ctrl #(
        .CLK_HZ    (1000),
        .BUZZ_HZ   (100),
        .ALARM_MS  (20),
        .MAX_FAIL  (3),
        .LOCKOUT_S (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Samples and stimulus changes both happen on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two-cycle input pulse; returns at the first sample after the DUT acts.
    task automatic pulse(input logic o, input logic a);
        bus.open_i  = o;
        bus.alarm_i = a;
        tick(2);
        bus.open_i  = 1'b0;
        bus.alarm_i = 1'b0;
        tick(1);
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.open_i  = 1'b0;
        bus.alarm_i = 1'b0;

        // ---------------- reset ----------------
        for (int i = 0; i < 6; i++) begin
            bus.open_i  = 1'($urandom_range(0, 1));
            bus.alarm_i = 1'($urandom_range(0, 1));
            tick(1);
        end
        check_val("rst_buzzer",   bus.buzzer,   0);
        check_val("rst_lockout",  bus.lockout,  0);
        check_val("rst_led_lock", bus.led_lock, 1);
        check_val("rst_fail_cnt", bus.fail_cnt, 0);
        bus.open_i  = 1'b0;
        bus.alarm_i = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        check_val("rel_buzzer",   bus.buzzer,   0);
        check_val("rel_lockout",  bus.lockout,  0);
        check_val("rel_led_lock", bus.led_lock, 1);
        check_val("rel_fail_cnt", bus.fail_cnt, 0);

        // ---------------- single fail ----------------
        bus.alarm_i = 1'b1;
        tick(2);
        check_val("fail_edge2", bus.fail_cnt, 0);
        tick(1);
        check_val("fail_edge3", bus.fail_cnt, 1);
        bus.alarm_i = 1'b0;
        for (int k = 0; k < 22; k++) begin
            check_val($sformatf("alarm_buz[%0d]", k), bus.buzzer,
                      (k < 20) ? ((k / 5) % 2) : 0);
            tick(1);
        end
        check_val("alarm_end_fail", bus.fail_cnt, 1);
        check_val("alarm_end_lock", bus.lockout,  0);

        // ---------------- recovery ----------------
        pulse(1'b1, 1'b0);
        check_val("clr_fail", bus.fail_cnt, 0);
        tick(5);
        pulse(1'b0, 1'b1);
        check_val("rec_fail1", bus.fail_cnt, 1);
        check_val("rec_lock1", bus.lockout,  0);
        tick(8);
        pulse(1'b0, 1'b1);
        check_val("rec_fail2", bus.fail_cnt, 2);
        check_val("rec_lock2", bus.lockout,  0);
        tick(4);
        pulse(1'b1, 1'b0);
        check_val("rec_fail0", bus.fail_cnt, 0);
        check_val("rec_buz0",  bus.buzzer,   0);
        check_val("rec_lock0", bus.lockout,  0);

        // ---------------- simultaneous open/alarm ----------------
        tick(30);
        pulse(1'b1, 1'b1);
        check_val("sim_fail",  bus.fail_cnt, 1);
        check_val("sim_buz0",  bus.buzzer,   0);
        tick(5);
        check_val("sim_buz5",  bus.buzzer,   1);
        tick(20);
        check_val("sim_end_fail", bus.fail_cnt, 1);
        check_val("sim_end_buz",  bus.buzzer,   0);
        pulse(1'b1, 1'b0);
        check_val("sim_clr", bus.fail_cnt, 0);

        // ---------------- lockout ----------------
        tick(30);
        pulse(1'b0, 1'b1);
        tick(27);
        pulse(1'b0, 1'b1);
        tick(27);
        bus.alarm_i = 1'b1;
        tick(2);
        check_val("lk_pre_lock", bus.lockout,  0);
        check_val("lk_pre_led",  bus.led_lock, 1);
        bus.alarm_i = 1'b0;
        tick(1);
        check_val("lk_lock", bus.lockout,  1);
        check_val("lk_led",  bus.led_lock, 0);
        check_val("lk_fail", bus.fail_cnt, 3);
        for (int k = 0; k < 1000; k++) begin
            check_val($sformatf("lk_buz[%0d]", k), bus.buzzer,
                      (k < 500) ? ((k / 5) % 2) : 0);
            if (k == 100) bus.open_i = 1'b1;
            if (k == 102) bus.open_i = 1'b0;
            if (k == 200) bus.alarm_i = 1'b1;
            if (k == 202) bus.alarm_i = 1'b0;
            if (k == 300) begin bus.open_i = 1'b1; bus.alarm_i = 1'b1; end
            if (k == 303) begin bus.open_i = 1'b0; bus.alarm_i = 1'b0; end
            if (k == 999) begin
                check_val("lk_hold_fail", bus.fail_cnt, 3);
                check_val("lk_hold_lock", bus.lockout,  1);
            end
            tick(1);
        end
        check_val("lk_exit_lock", bus.lockout,  0);
        check_val("lk_exit_led",  bus.led_lock, 1);
        check_val("lk_exit_fail", bus.fail_cnt, 0);
        check_val("lk_exit_buz",  bus.buzzer,   0);

        // ---------------- open from idle (chirp when enabled) ----------------
        tick(5);
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 104; k++) begin
`ifdef BEEP_ON_OPEN_EN
            check_val($sformatf("open_buz[%0d]", k), bus.buzzer,
                      (k < 100) ? ((k / 2) % 2) : 0);
`else
            check_val($sformatf("open_buz[%0d]", k), bus.buzzer, 0);
`endif
            tick(1);
        end
        check_val("open_fail", bus.fail_cnt, 0);

        // ---------------- reset mid-lockout ----------------
        pulse(1'b0, 1'b1);
        tick(27);
        pulse(1'b0, 1'b1);
        tick(27);
        pulse(1'b0, 1'b1);
        tick(405);
        check_val("mid_pre_lock", bus.lockout, 1);
        check_val("mid_pre_buz",  bus.buzzer,  1);
        bus.alarm_i = 1'b1;
        rst_n       = 1'b0;
        #1;
        check_val("mid_rst_lock", bus.lockout,  0);
        check_val("mid_rst_buz",  bus.buzzer,   0);
        check_val("mid_rst_led",  bus.led_lock, 1);
        check_val("mid_rst_fail", bus.fail_cnt, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_val("post_rst_edge2", bus.fail_cnt, 0);
        tick(1);
        check_val("post_rst_edge3", bus.fail_cnt, 1);
        bus.alarm_i = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
